// File: rtl/lsu_pkg.sv
// Shared LSU types: access sizes, exception causes, FSM state encoding and
// the natural-alignment rule used to screen incoming memory ops.
package lsu_pkg;

   typedef enum logic [1:0] {
      MEM_SIZE_B = 2'd0,
      MEM_SIZE_H = 2'd1,
      MEM_SIZE_W = 2'd2
   } mem_read_size_t;

   typedef enum logic [1:0] {
      EXC_LD_MISALIGN = 2'd0,
      EXC_ST_MISALIGN = 2'd1,
      EXC_TIMEOUT     = 2'd2,
      EXC_ILLEGAL     = 2'd3
   } lsu_exc_t;

   typedef logic [1:0] lsu_state_t;

   localparam lsu_state_t S_IDLE = 2'd0;
   localparam lsu_state_t S_REQ  = 2'd1;
   localparam lsu_state_t S_WAIT = 2'd2;

   function automatic logic is_aligned(input logic [31:0] addr, input mem_read_size_t size);
      case (size)
         MEM_SIZE_B: return 1'b1;
         MEM_SIZE_H: return ~addr[0];
         default:    return (addr[1:0] == 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// LSU <-> dcache request/response bus; master is the LSU, slave the dcache.
import lsu_pkg::*;

interface lsu_if;
   logic           dc_req_valid;
   logic           dc_write_en;
   logic [31:0]    dc_req_addr;
   logic [31:0]    dc_write_data;
   mem_read_size_t dc_size;
   logic           dc_sign;
   logic           dc_resp_ready;
   logic           dc_resp_valid;
   logic [31:0]    dc_resp_data;

   modport master (
      output dc_req_valid, dc_write_en, dc_req_addr, dc_write_data, dc_size, dc_sign,
      input  dc_resp_ready, dc_resp_valid, dc_resp_data
   );

   modport slave (
      input  dc_req_valid, dc_write_en, dc_req_addr, dc_write_data, dc_size, dc_sign,
      output dc_resp_ready, dc_resp_valid, dc_resp_data
   );
endinterface

// File: rtl/lsu.sv
// Load/store unit: screens EX-stage memory ops, issues one dcache request per
// op, returns load data to writeback and raises misalign/illegal/timeout faults.
import lsu_pkg::*;

module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ex_valid,
   input  logic           ex_mem_read,
   input  logic           ex_mem_write,
   input  logic [31:0]    ex_addr,
   input  logic [31:0]    ex_wdata,
   input  mem_read_size_t ex_size,
   input  logic           ex_sign,
   input  logic [4:0]     ex_rd,
   output logic           lsu_busy,
   output logic           wb_valid,
   output logic [4:0]     wb_rd,
   output logic [31:0]    wb_data,
   output logic           exc_valid,
   output lsu_exc_t       exc_cause,
   lsu_if.master          dc
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_t     state;
   logic [CW-1:0]  wait_cnt;
   logic [4:0]     lat_rd;
   logic           lat_write;
   logic [31:0]    lat_addr;
   logic [31:0]    lat_wdata;
   mem_read_size_t lat_size;
   logic           lat_sign;

   logic ex_one_op;
   logic ex_aligned;
   logic accept;

   assign ex_one_op  = ex_mem_read ^ ex_mem_write;
   assign ex_aligned = is_aligned(ex_addr, ex_size);
   assign accept     = (state == S_IDLE) && ex_valid && ex_one_op && ex_aligned;

   // Stall is asserted in the accepting cycle itself so EX holds the op.
   assign lsu_busy = accept || (state == S_REQ) || (state == S_WAIT);

   // The request is offered only while the dcache reports ready, so it lasts
   // exactly the one cycle in which REQ hands over to WAIT.
   assign dc.dc_req_valid  = (state == S_REQ) && dc.dc_resp_ready;
   assign dc.dc_write_en   = lat_write;
   assign dc.dc_req_addr   = lat_addr;
   assign dc.dc_write_data = lat_wdata;
   assign dc.dc_size       = lat_size;
   assign dc.dc_sign       = lat_sign;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         wb_valid  <= 1'b0;
         wb_rd     <= '0;
         wb_data   <= '0;
         exc_valid <= 1'b0;
         exc_cause <= EXC_LD_MISALIGN;
         lat_rd    <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_size  <= MEM_SIZE_W;
         lat_sign  <= 1'b0;
      end else begin
         wb_valid  <= 1'b0;
         exc_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ex_valid) begin
                  if (ex_mem_read && ex_mem_write) begin
                     exc_valid <= 1'b1;
                     exc_cause <= EXC_ILLEGAL;
                  end else if (ex_one_op && !ex_aligned) begin
                     exc_valid <= 1'b1;
                     exc_cause <= ex_mem_read ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
                  end else if (ex_one_op) begin
                     lat_rd    <= ex_rd;
                     lat_write <= ex_mem_write;
                     lat_addr  <= ex_addr;
                     lat_wdata <= ex_wdata;
                     lat_size  <= ex_size;
                     lat_sign  <= ex_sign;
                     state     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (dc.dc_resp_ready) begin
                  wait_cnt <= '0;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dc.dc_resp_valid) begin
                  wait_cnt <= '0;
                  state    <= S_IDLE;
                  if (!lat_write && (lat_rd != 5'd0)) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= lat_rd;
                     wb_data  <= dc.dc_resp_data;
                  end
               end else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  wait_cnt  <= '0;
                  state     <= S_IDLE;
                  exc_valid <= 1'b1;
                  exc_cause <= EXC_TIMEOUT;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, randomized ops against a
// byte-memory dcache model, plus timeout/late-response and reset-in-WAIT sequences.
import lsu_pkg::*;

module tb_lsu;

   localparam int TMO = 8;

   typedef enum int {R_WB, R_SILENT, R_EXC, R_IGNORED, R_TIMEOUT} res_t;

   typedef struct {
      logic           rd_op;
      logic           wr_op;
      logic [31:0]    addr;
      logic [31:0]    wdata;
      mem_read_size_t size;
      logic           sgn;
      logic [4:0]     rd;
      int             rdy_dly;
      int             lat;       // 0: dcache never answers
      res_t           res;
      logic [31:0]    exp_data;
      lsu_exc_t       exp_cause;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           ex_valid, ex_mem_read, ex_mem_write, ex_sign;
   logic [31:0]    ex_addr, ex_wdata;
   mem_read_size_t ex_size;
   logic [4:0]     ex_rd;
   logic           lsu_busy, wb_valid, exc_valid;
   logic [4:0]     wb_rd;
   logic [31:0]    wb_data;
   lsu_exc_t       exc_cause;

   lsu_if dc_bus ();

   lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_size(ex_size), .ex_sign(ex_sign),
      .ex_rd(ex_rd), .lsu_busy(lsu_busy),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .exc_valid(exc_valid), .exc_cause(exc_cause),
      .dc(dc_bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] mem_q [logic [31:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic int nbytes(input mem_read_size_t s);
      return (s == MEM_SIZE_B) ? 1 : (s == MEM_SIZE_H) ? 2 : 4;
   endfunction

   function automatic logic [7:0] byte_at(input logic [31:0] a);
      return mem_q.exists(a) ? mem_q[a] : 8'h00;
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a, input mem_read_size_t s, input logic sg);
      logic [31:0] v;
      int nb;
      v  = '0;
      nb = nbytes(s);
      for (int i = 0; i < nb; i++) v[8*i +: 8] = byte_at(a + 32'(i));
      if (sg && nb < 4 && v[8*nb-1])
         for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic mem_wr(input logic [31:0] a, input mem_read_size_t s, input logic [31:0] d);
      for (int i = 0; i < nbytes(s); i++) mem_q[a + 32'(i)] = d[8*i +: 8];
   endtask

   function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                               input mem_read_size_t s, input logic sg, input logic [4:0] rd,
                               input int dly, input int lat, input res_t res,
                               input logic [31:0] ed, input lsu_exc_t ec);
      vec_t v;
      v.rd_op = r; v.wr_op = w; v.addr = a; v.wdata = d; v.size = s; v.sgn = sg; v.rd = rd;
      v.rdy_dly = dly; v.lat = lat; v.res = res; v.exp_data = ed; v.exp_cause = ec;
      return v;
   endfunction

   // Expected outcome derived from the architectural rules alone.
   function automatic vec_t classify(input vec_t v);
      vec_t o;
      o = v;
      o.exp_data  = '0;
      o.exp_cause = EXC_LD_MISALIGN;
      if (v.rd_op && v.wr_op) begin
         o.res = R_EXC; o.exp_cause = EXC_ILLEGAL;
      end else if (!v.rd_op && !v.wr_op) begin
         o.res = R_IGNORED;
      end else if ((v.addr % nbytes(v.size)) != 0) begin
         o.res = R_EXC; o.exp_cause = v.rd_op ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
      end else if (v.lat == 0) begin
         o.res = R_TIMEOUT; o.exp_cause = EXC_TIMEOUT;
      end else if (v.wr_op || v.rd == 5'd0) begin
         o.res = R_SILENT;
      end else begin
         o.res = R_WB; o.exp_data = mem_rd(v.addr, v.size, v.sgn);
      end
      return o;
   endfunction

   task automatic do_op(input vec_t v, input string tag);
      logic [31:0] resp;
      int n;
      ex_valid = 1'b1; ex_mem_read = v.rd_op; ex_mem_write = v.wr_op;
      ex_addr = v.addr; ex_wdata = v.wdata; ex_size = v.size; ex_sign = v.sgn; ex_rd = v.rd;
      dc_bus.dc_resp_ready = 1'b0; dc_bus.dc_resp_valid = 1'b0; dc_bus.dc_resp_data = '0;
      #1;
      if (v.res == R_EXC || v.res == R_IGNORED) begin
         chk({tag, " busy0"}, 32'(lsu_busy), 0);
         chk({tag, " noreq0"}, 32'(dc_bus.dc_req_valid), 0);
         next_cycle();
         ex_valid = 1'b0;
         #1;
         chk({tag, " exc_valid"}, 32'(exc_valid), (v.res == R_EXC) ? 1 : 0);
         if (v.res == R_EXC) chk({tag, " exc_cause"}, 32'(exc_cause), 32'(v.exp_cause));
         chk({tag, " no_wb"}, 32'(wb_valid), 0);
         chk({tag, " noreq1"}, 32'(dc_bus.dc_req_valid), 0);
         chk({tag, " busy1"}, 32'(lsu_busy), 0);
      end else begin
         chk({tag, " busy_accept"}, 32'(lsu_busy), 1);
         for (int i = 0; i < v.rdy_dly; i++) begin
            next_cycle();
            dc_bus.dc_resp_ready = 1'b0;
            #1;
            chk({tag, " held_req"}, 32'(dc_bus.dc_req_valid), 0);
            chk({tag, " held_busy"}, 32'(lsu_busy), 1);
         end
         next_cycle();
         dc_bus.dc_resp_ready = 1'b1;
         #1;
         chk({tag, " req_valid"}, 32'(dc_bus.dc_req_valid), 1);
         chk({tag, " req_addr"}, dc_bus.dc_req_addr, v.addr);
         chk({tag, " req_we"}, 32'(dc_bus.dc_write_en), 32'(v.wr_op));
         chk({tag, " req_wdata"}, dc_bus.dc_write_data, v.wdata);
         chk({tag, " req_size"}, 32'(dc_bus.dc_size), 32'(v.size));
         chk({tag, " req_sign"}, 32'(dc_bus.dc_sign), 32'(v.sgn));
         // dcache model acts on what the DUT actually requested
         resp = 32'h5A5A_5A5A;
         if (dc_bus.dc_write_en) mem_wr(dc_bus.dc_req_addr, dc_bus.dc_size, dc_bus.dc_write_data);
         else resp = mem_rd(dc_bus.dc_req_addr, dc_bus.dc_size, dc_bus.dc_sign);
         n = (v.lat == 0) ? TMO : v.lat;
         for (int i = 1; i <= n; i++) begin
            next_cycle();
            dc_bus.dc_resp_ready = 1'b0;
            dc_bus.dc_resp_valid = (i == v.lat);
            dc_bus.dc_resp_data  = (i == v.lat) ? resp : $urandom;
            #1;
            chk({tag, " wait_req"}, 32'(dc_bus.dc_req_valid), 0);
            chk({tag, " wait_busy"}, 32'(lsu_busy), 1);
            chk({tag, " wait_addr"}, dc_bus.dc_req_addr, v.addr);
            chk({tag, " wait_pulses"}, {30'd0, wb_valid, exc_valid}, 0);
         end
         next_cycle();
         dc_bus.dc_resp_valid = 1'b0;
         dc_bus.dc_resp_ready = 1'b1;
         ex_valid = 1'b0;
         #1;
         chk({tag, " wb_valid"}, 32'(wb_valid), (v.res == R_WB) ? 1 : 0);
         if (v.res == R_WB) begin
            chk({tag, " wb_data"}, wb_data, v.exp_data);
            chk({tag, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
         end
         chk({tag, " exc_valid"}, 32'(exc_valid), (v.res == R_TIMEOUT) ? 1 : 0);
         if (v.res == R_TIMEOUT) chk({tag, " exc_cause"}, 32'(exc_cause), 32'(EXC_TIMEOUT));
         chk({tag, " done_busy"}, 32'(lsu_busy), 0);
         chk({tag, " done_req"}, 32'(dc_bus.dc_req_valid), 0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"}, 32'(lsu_busy), 0);
      chk({tag, " pulses"}, {30'd0, wb_valid, exc_valid}, 0);
      chk({tag, " wb_rd/data"}, {27'd0, wb_rd} | wb_data, 0);
      chk({tag, " exc_cause"}, 32'(exc_cause), 0);
      chk({tag, " req_valid"}, 32'(dc_bus.dc_req_valid), 0);
      chk({tag, " req_fields"}, dc_bus.dc_req_addr | dc_bus.dc_write_data |
          {30'd0, dc_bus.dc_write_en, dc_bus.dc_sign}, 0);
      chk({tag, " dc_size"}, 32'(dc_bus.dc_size), 32'(MEM_SIZE_W));
   endtask

   vec_t tbl [$];
   vec_t rv;

   initial begin
      rst = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      ex_addr = '0; ex_wdata = '0; ex_size = MEM_SIZE_W; ex_sign = 1'b0; ex_rd = '0;
      dc_bus.dc_resp_ready = 1'b1; dc_bus.dc_resp_valid = 1'b0; dc_bus.dc_resp_data = '0;
      next_cycle();
      next_cycle();
      chk_all_zero("reset");
      rst = 1'b0;
      next_cycle();

      tbl.push_back(mk(0, 1, 32'h1004, 32'h1122_3344, MEM_SIZE_W, 0, 5'd0,  0, 3, R_SILENT, 0, EXC_LD_MISALIGN));
      tbl.push_back(mk(1, 0, 32'h1004, 32'h0,         MEM_SIZE_W, 0, 5'd7,  0, 1, R_WB, 32'h1122_3344, EXC_LD_MISALIGN));
      tbl.push_back(mk(0, 1, 32'h1002, 32'h0000_8788, MEM_SIZE_H, 0, 5'd0,  0, 2, R_SILENT, 0, EXC_LD_MISALIGN));
      tbl.push_back(mk(1, 0, 32'h1002, 32'h0,         MEM_SIZE_H, 1, 5'd3,  0, 1, R_WB, 32'hFFFF_8788, EXC_LD_MISALIGN));
      tbl.push_back(mk(1, 0, 32'h1002, 32'h0,         MEM_SIZE_H, 0, 5'd4,  0, 4, R_WB, 32'h0000_8788, EXC_LD_MISALIGN));
      tbl.push_back(mk(1, 0, 32'h1001, 32'h0,         MEM_SIZE_W, 0, 5'd8,  0, 1, R_EXC, 0, EXC_LD_MISALIGN));
      tbl.push_back(mk(0, 1, 32'h1003, 32'hBEEF,      MEM_SIZE_H, 0, 5'd0,  0, 1, R_EXC, 0, EXC_ST_MISALIGN));
      tbl.push_back(mk(1, 1, 32'h1000, 32'h0,         MEM_SIZE_W, 0, 5'd9,  0, 1, R_EXC, 0, EXC_ILLEGAL));
      tbl.push_back(mk(0, 0, 32'h1000, 32'h0,         MEM_SIZE_W, 0, 5'd9,  0, 1, R_IGNORED, 0, EXC_LD_MISALIGN));
      tbl.push_back(mk(1, 0, 32'h1003, 32'h0,         MEM_SIZE_B, 1, 5'd12, 5, 2, R_WB, 32'hFFFF_FF87, EXC_LD_MISALIGN));
      tbl.push_back(mk(1, 0, 32'h1005, 32'h0,         MEM_SIZE_B, 0, 5'd13, 0, 1, R_WB, 32'h0000_0033, EXC_LD_MISALIGN));
      tbl.push_back(mk(1, 0, 32'h1006, 32'h0,         MEM_SIZE_H, 0, 5'd6,  0, 1, R_WB, 32'h0000_1122, EXC_LD_MISALIGN));
      tbl.push_back(mk(1, 0, 32'h1004, 32'h0,         MEM_SIZE_W, 0, 5'd0,  0, 8, R_SILENT, 0, EXC_LD_MISALIGN));
      tbl.push_back(mk(1, 0, 32'h1004, 32'h0,         MEM_SIZE_W, 0, 5'd31, 0, 8, R_WB, 32'h1122_3344, EXC_LD_MISALIGN));
      tbl.push_back(mk(1, 0, 32'h1000, 32'h0,         MEM_SIZE_W, 0, 5'd1,  0, 0, R_TIMEOUT, 0, EXC_TIMEOUT));

      foreach (tbl[i]) do_op(tbl[i], $sformatf("vec%0d", i));

      // Stray response after the timeout must be dropped.
      next_cycle();
      dc_bus.dc_resp_valid = 1'b1;
      dc_bus.dc_resp_data  = 32'hDEAD_BEEF;
      #1;
      next_cycle();
      dc_bus.dc_resp_valid = 1'b0;
      #1;
      chk("late_resp pulses", {30'd0, wb_valid, exc_valid}, 0);
      chk("late_resp busy", 32'(lsu_busy), 0);
      do_op(mk(1, 0, 32'h1004, 32'h0, MEM_SIZE_W, 0, 5'd2, 0, 2, R_WB, 32'h1122_3344, EXC_LD_MISALIGN),
            "after_timeout");

      // Reset while waiting on the dcache abandons the op.
      mem_wr(32'h2000, MEM_SIZE_W, 32'hAAAA_AAAA);
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
      ex_addr = 32'h1004; ex_size = MEM_SIZE_W; ex_sign = 1'b0; ex_rd = 5'd5;
      dc_bus.dc_resp_ready = 1'b1;
      next_cycle();
      #1;
      chk("rstseq req", 32'(dc_bus.dc_req_valid), 1);
      next_cycle();
      dc_bus.dc_resp_ready = 1'b0;
      next_cycle();
      rst = 1'b1;
      ex_valid = 1'b0;
      next_cycle();
      rst = 1'b0;
      dc_bus.dc_resp_valid = 1'b1;
      dc_bus.dc_resp_data  = 32'h1122_3344;
      #1;
      chk_all_zero("rst_in_wait");
      next_cycle();
      dc_bus.dc_resp_valid = 1'b0;
      #1;
      chk("post_rst pulses", {30'd0, wb_valid, exc_valid}, 0);
      chk("post_rst busy", 32'(lsu_busy), 0);
      do_op(mk(1, 0, 32'h2000, 32'h0, MEM_SIZE_W, 0, 5'd9, 0, 1, R_WB, 32'hAAAA_AAAA, EXC_LD_MISALIGN),
            "post_rst_load");

      for (int k = 0; k < 150; k++) begin
         int op;
         op = $urandom_range(0, 9);
         rv.rd_op   = (op == 1) || (op >= 2 && op <= 5);
         rv.wr_op   = (op == 1) || (op >= 6);
         rv.addr    = 32'h3000 + $urandom_range(0, 15);
         rv.wdata   = $urandom;
         rv.size    = mem_read_size_t'($urandom_range(0, 2));
         rv.sgn     = 1'($urandom_range(0, 1));
         rv.rd      = 5'($urandom_range(0, 31));
         rv.rdy_dly = $urandom_range(0, 3);
         rv.lat     = $urandom_range(0, TMO);
         do_op(classify(rv), $sformatf("rnd%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
